// File: rtl/nono_gen_pkg.sv
// rtl/nono_gen_pkg.sv - shared types and constants for the generator launcher
package nono_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ABORT  = 2'd3
    } gen_state_t;

    localparam int PIXEL_W_DEFAULT = 12;
    localparam int RUN_COUNT_W     = 8;

endpackage

// File: rtl/nono_gen_launcher_btn_debounce.sv
// rtl/nono_gen_launcher_btn_debounce.sv - button synchronizer and single-pulse debouncer
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_btn,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Counter saturates at CNT_MAX so the pulse fires once per held press.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (!r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt   <= r_cnt + CNT_ONE;
                r_press <= (r_cnt == CNT_MAX - CNT_ONE);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/nono_gen_launcher.sv
// rtl/nono_gen_launcher.sv - launches the nonogram generator, supervises timeout, captures result
module nono_gen_launcher
    import nono_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int TIMEOUT_CYCLES  = 65_536,
    parameter int PIXEL_W         = PIXEL_W_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   btn_in,
    input  logic                   gen_done_in,
    input  logic [PIXEL_W-1:0]     gen_pixel_in,
    output logic                   gen_start_out,
    output logic                   gen_reset_out,
    output logic                   busy_out,
    output logic                   result_valid_out,
    output logic [PIXEL_W-1:0]     result_pixel_out,
    output logic                   timeout_out,
    output logic [RUN_COUNT_W-1:0] run_count_out
);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [RUN_COUNT_W-1:0] RUN_ONE = RUN_COUNT_W'(1);

    gen_state_t             r_state;
    logic                   r_pending;
    logic                   r_done_prev;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic                   r_gen_start;
    logic                   r_gen_reset;
    logic                   r_busy;
    logic                   r_result_valid;
    logic [PIXEL_W-1:0]     r_result_pixel;
    logic                   r_timeout;
    logic [RUN_COUNT_W-1:0] r_run_count;

    logic w_press;
    logic w_complete;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk    (clk_in),
        .i_resetn (reset_n_in),
        .i_btn    (btn_in),
        .o_press  (w_press)
    );

    // Only a fresh rising edge of done counts; a level left over from a prior run does not.
    assign w_complete = gen_done_in & ~r_done_prev;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_state        <= ST_IDLE;
            r_pending      <= 1'b0;
            r_done_prev    <= 1'b0;
            r_wait_cnt     <= '0;
            r_gen_start    <= 1'b0;
            r_gen_reset    <= 1'b1;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_pixel <= '0;
            r_timeout      <= 1'b0;
            r_run_count    <= '0;
        end else begin
            r_done_prev    <= gen_done_in;
            r_gen_start    <= 1'b0;
            r_gen_reset    <= 1'b0;
            r_result_valid <= 1'b0;
            if (w_press && r_state != ST_IDLE) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_press || r_pending) begin
                        r_state     <= ST_LAUNCH;
                        r_pending   <= 1'b0;
                        r_gen_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                    if (w_complete) begin
                        r_result_pixel <= gen_pixel_in;
                        r_result_valid <= 1'b1;
                        r_run_count    <= r_run_count + RUN_ONE;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_gen_reset <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_state     <= ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gen_start_out    = r_gen_start;
    assign gen_reset_out    = r_gen_reset;
    assign busy_out         = r_busy;
    assign result_valid_out = r_result_valid;
    assign result_pixel_out = r_result_pixel;
    assign timeout_out      = r_timeout;
    assign run_count_out    = r_run_count;

endmodule

// File: tb/tb_nono_gen_launcher.sv
// tb/tb_nono_gen_launcher.sv - directed self-checking bench for nono_gen_launcher
module tb_nono_gen_launcher;

    logic        clk;
    logic        reset_n;
    logic        btn;
    logic        gen_done;
    logic [11:0] gen_pixel;
    logic        gen_start_out;
    logic        gen_reset_out;
    logic        busy_out;
    logic        result_valid_out;
    logic [11:0] result_pixel_out;
    logic        timeout_out;
    logic [7:0]  run_count_out;

    logic manual;
    logic man_done;
    logic auto_done;
    int   auto_cnt;
    int   cyc;
    int   g_start_cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic        completes;
        logic [11:0] pixel;
        logic        exp_valid;
        logic [11:0] exp_pixel;
        logic [7:0]  exp_count;
        logic        exp_timeout;
        int          exp_latency;
    } vec_t;

    vec_t vecs[3];

    nono_gen_launcher #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (100),
        .PIXEL_W        (12)
    ) dut (
        .clk_in           (clk),
        .reset_n_in       (reset_n),
        .btn_in           (btn),
        .gen_done_in      (gen_done),
        .gen_pixel_in     (gen_pixel),
        .gen_start_out    (gen_start_out),
        .gen_reset_out    (gen_reset_out),
        .busy_out         (busy_out),
        .result_valid_out (result_valid_out),
        .result_pixel_out (result_pixel_out),
        .timeout_out      (timeout_out),
        .run_count_out    (run_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: raises done 20 cycles after a start pulse and holds it.
    initial begin
        auto_cnt  = 0;
        auto_done = 1'b0;
    end
    always @(negedge clk) begin
        if (gen_start_out) begin
            auto_cnt  = 20;
            auto_done = 1'b0;
        end else if (auto_cnt > 0) begin
            auto_cnt = auto_cnt - 1;
            if (auto_cnt == 0) auto_done = 1'b1;
        end
    end

    assign gen_done = manual ? man_done : auto_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_press(input int hold, output int starts);
        starts = 0;
        btn = 1'b1;
        for (int i = 0; i < hold + 3; i++) begin
            @(negedge clk);
            if (gen_start_out) begin
                starts++;
                g_start_cyc = cyc;
                check("busy at start", busy_out, 1);
                check("timeout clear at launch", timeout_out, 0);
            end
            if (i == hold - 1) btn = 1'b0;
        end
    endtask

    task automatic wait_result(input int bound, output bit got_valid, output bit got_abort,
                               output int ev_cyc);
        got_valid = 0;
        got_abort = 0;
        ev_cyc    = -1;
        for (int i = 0; i < bound && !got_valid && !got_abort; i++) begin
            @(negedge clk);
            if (result_valid_out) begin
                got_valid = 1;
                ev_cyc    = cyc;
            end else if (gen_reset_out) begin
                got_abort = 1;
                ev_cyc    = cyc;
            end
        end
        if (!got_valid && !got_abort) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_result: no valid or abort within %0d cycles", bound);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   starts;
        int   ev;
        int   nval;
        bit   gv;
        bit   ga;
        logic [7:0] exp_count;

        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        btn       = 1'b0;
        manual    = 1'b0;
        man_done  = 1'b0;
        gen_pixel = 12'h000;
        g_start_cyc = 0;

        vecs[0] = '{1'b1, 12'h1FF, 1'b1, 12'h1FF, 8'd1, 1'b0, 21};
        vecs[1] = '{1'b0, 12'hABC, 1'b0, 12'h1FF, 8'd1, 1'b1, 101};
        vecs[2] = '{1'b1, 12'h123, 1'b1, 12'h123, 8'd2, 1'b0, 21};

        repeat (3) @(negedge clk);
        check("rst gen_start", gen_start_out, 0);
        check("rst gen_reset", gen_reset_out, 1);
        check("rst busy", busy_out, 0);
        check("rst valid", result_valid_out, 0);
        check("rst pixel", result_pixel_out, 0);
        check("rst timeout", timeout_out, 0);
        check("rst count", run_count_out, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("gen_reset drops after reset", gen_reset_out, 0);
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            manual    = !vecs[v].completes;
            man_done  = 1'b0;
            gen_pixel = vecs[v].pixel;
            do_press(10, starts);
            check($sformatf("v%0d start pulses", v), starts, 1);
            wait_result(150, gv, ga, ev);
            check($sformatf("v%0d valid", v), gv, vecs[v].exp_valid);
            check($sformatf("v%0d abort", v), ga, !vecs[v].exp_valid);
            check($sformatf("v%0d latency", v), ev - g_start_cyc, vecs[v].exp_latency);
            if (gv) begin
                check($sformatf("v%0d pixel at valid", v), result_pixel_out, vecs[v].exp_pixel);
                check($sformatf("v%0d count at valid", v), run_count_out, vecs[v].exp_count);
                check($sformatf("v%0d busy at valid", v), busy_out, 0);
            end
            @(negedge clk);
            check($sformatf("v%0d valid one cycle", v), result_valid_out, 0);
            check($sformatf("v%0d gen_reset one cycle", v), gen_reset_out, 0);
            check($sformatf("v%0d busy after", v), busy_out, 0);
            check($sformatf("v%0d pixel held", v), result_pixel_out, vecs[v].exp_pixel);
            check($sformatf("v%0d count", v), run_count_out, vecs[v].exp_count);
            check($sformatf("v%0d timeout", v), timeout_out, vecs[v].exp_timeout);
        end
        exp_count = 8'd2;

        // Glitch of 3 cycles must not launch.
        do_press(3, starts);
        check("glitch no start", starts, 0);

        // Two presses during one run: one relaunch, done held high across it.
        manual   = 1'b1;
        man_done = 1'b0;
        do_press(10, starts);
        check("pend first start", starts, 1);
        do_press(8, starts);
        check("pend press in run", starts, 0);
        do_press(8, starts);
        check("pend dropped press", starts, 0);
        gen_pixel = 12'h0AA;
        man_done  = 1'b1;
        wait_result(10, gv, ga, ev);
        exp_count = exp_count + 8'd1;
        check("pend run1 valid", gv, 1);
        check("pend run1 pixel", result_pixel_out, 12'h0AA);
        check("pend run1 count", run_count_out, exp_count);
        @(negedge clk);
        check("pend relaunch at C+2", gen_start_out, 1);
        nval = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (result_valid_out) nval++;
        end
        check("held done not completion", nval, 0);
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        gen_pixel = 12'h055;
        man_done  = 1'b1;
        wait_result(10, gv, ga, ev);
        exp_count = exp_count + 8'd1;
        check("pend run2 valid", gv, 1);
        check("pend run2 pixel", result_pixel_out, 12'h055);
        check("pend run2 count", run_count_out, exp_count);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gen_start_out) starts++;
        end
        check("no third launch", starts, 0);

        // Completion on the final WAIT cycle beats the timeout.
        man_done  = 1'b0;
        gen_pixel = 12'h3C3;
        do_press(10, starts);
        check("tie start", starts, 1);
        for (int i = 0; i < 200 && cyc != g_start_cyc + 100; i++) @(negedge clk);
        man_done = 1'b1;
        wait_result(10, gv, ga, ev);
        exp_count = exp_count + 8'd1;
        check("tie valid", gv, 1);
        check("tie no abort", ga, 0);
        check("tie latency", ev - g_start_cyc, 101);
        check("tie pixel", result_pixel_out, 12'h3C3);
        check("tie timeout", timeout_out, 0);
        check("tie count", run_count_out, exp_count);

        // Reset mid-WAIT with a pending press.
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        do_press(10, starts);
        check("midrst start", starts, 1);
        do_press(8, starts);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst gen_reset", gen_reset_out, 1);
        check("midrst busy", busy_out, 0);
        check("midrst start", gen_start_out, 0);
        check("midrst valid", result_valid_out, 0);
        check("midrst pixel", result_pixel_out, 0);
        check("midrst timeout", timeout_out, 0);
        check("midrst count", run_count_out, 0);
        reset_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (gen_start_out) starts++;
        end
        check("midrst pending dropped", starts, 0);
        check("midrst idle busy", busy_out, 0);

        // 256 completed runs wrap the counter.
        manual = 1'b0;
        nval   = 0;
        for (int i = 0; i < 256; i++) begin
            gen_pixel = 12'(i);
            do_press(10, starts);
            wait_result(60, gv, ga, ev);
            if (gv) nval++;
            if (i == 254) check("count reaches 255", run_count_out, 255);
        end
        check("wrap completions", nval, 256);
        check("count wraps to 0", run_count_out, 0);
        check("wrap last pixel", result_pixel_out, 12'h0FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nono_gen_launcher.md
# nono_gen_launcher

Control stage directly upstream of the nonogram generator. Turns a raw push-button into a single-cycle generator start pulse, supervises the run with a timeout, and captures the generator's pixel result on completion. Feeds the generator's start input and consumes its `done`/pixel outputs; downstream display logic reads the captured result.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500_000: consecutive stable-high cycles required before a press is accepted.
- `TIMEOUT_CYCLES`, 65_536: maximum WAIT cycles before the run is aborted; must exceed generator run length (50_000).
- `PIXEL_W`, 12: pixel width.

Ports:
- `clk_in` input 1: single clock.
- `reset_n_in` input 1: reset; one clock; reset is synchronous and active-low.
- `btn_in` input 1: raw asynchronous button, active-high.
- `gen_done_in` input 1: generator done level.
- `gen_pixel_in` input PIXEL_W: generator pixel output.
- `gen_start_out` output 1: one-cycle start pulse to generator.
- `gen_reset_out` output 1: active-high reset to generator.
- `busy_out` output 1: high in LAUNCH, WAIT and ABORT.
- `result_valid_out` output 1: one-cycle pulse when a result is captured.
- `result_pixel_out` output PIXEL_W: last captured pixel, held.
- `timeout_out` output 1: sticky abort flag.
- `run_count_out` output 8: completed-run counter.

## Operation
- Debouncer: 2-flop synchronizer on `btn_in`; counter increments while synced level is high, clears when low; press pulse emitted exactly once, on the cycle the count reaches DEBOUNCE_CYCLES; no further pulse until synced level returns low.
- States: IDLE, LAUNCH, WAIT, ABORT.
- IDLE: on press pulse or `pending` set -> LAUNCH, clear `pending`.
- LAUNCH (1 cycle): `gen_start_out`=1, clear `timeout_out`, clear wait counter -> WAIT.
- WAIT: wait counter increments each cycle. Completion = `gen_done_in` high and registered previous `gen_done_in` low. On completion: `result_pixel_out`<=`gen_pixel_in`, `result_valid_out`=1 next cycle, `run_count_out`+1 (wraps 255->0) -> IDLE. If wait counter reaches TIMEOUT_CYCLES-1 without completion -> ABORT.
- ABORT (1 cycle): `gen_reset_out`=1, `timeout_out`<=1 -> IDLE.
- Press during LAUNCH/WAIT/ABORT sets `pending` (one deep; further presses dropped).
- A `gen_done_in` level already high from a prior run never counts as completion; only a rising edge seen in WAIT.

## Timing
- Reset values: `gen_start_out` 0, `gen_reset_out` 1, `busy_out` 0, `result_valid_out` 0, `result_pixel_out` 0, `timeout_out` 0, `run_count_out` 0, state IDLE, `pending` 0, debounce and wait counters 0, done-prev 0.
- `gen_reset_out` drops to 0 the first cycle after reset deasserts; high again only in ABORT.
- All outputs registered.
- Press pulse in cycle P -> `gen_start_out` high in cycle P+1 (from IDLE).
- Completion edge sampled in cycle C -> `result_valid_out`, new `result_pixel_out`, incremented count visible in cycle C+1; state IDLE in C+1, LAUNCH in C+2 if `pending`.
- Completion and timeout in same cycle: completion wins, no abort.
- Reset asserted mid-WAIT: all state to reset values next edge, `pending` dropped, `gen_reset_out` high.

## Structure
- Package `nono_gen_pkg`: state enum typedef (IDLE, LAUNCH, WAIT, ABORT), `PIXEL_W` default constant, run-count width constant.
- One sub-module: `btn_debounce` (synchronizer + stable counter + single press pulse), parameterized by DEBOUNCE_CYCLES.
- Counter widths via `$clog2` of respective parameters.

## Test plan
Use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, generator model completing in 20 cycles.
- Button high 10 cycles -> exactly one `gen_start_out` pulse; `busy_out` high from that cycle.
- Generator raises done with pixel 12'h1FF 20 cycles after start -> `result_valid_out` one cycle, `result_pixel_out`=12'h1FF, `run_count_out`=1, `busy_out` 0.
- Generator never raises done -> ABORT after 100 WAIT cycles, `gen_reset_out` one-cycle pulse, `timeout_out`=1; next press clears `timeout_out` in LAUNCH.
- Button glitches high 3 cycles -> no start; two presses within one run -> exactly one relaunch, two completions, count 2.
- `gen_done_in` held high from prior run across new launch, then low, then high -> only the new rising edge captured.
- `reset_n_in` low at WAIT cycle 10 -> all outputs at reset values next cycle, `gen_reset_out` 1; 256 completed runs -> `run_count_out` wraps to 0.
